oam_dma_ctrl: RTL



---
 rtl/oam_dma_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: captures FF46 writes, waits out the startup delay, then streams
// NUM_BYTES source bytes into OAM with CPU bus gating and interrupt masking.
module oam_dma_ctrl #(
  parameter int NUM_BYTES     = 160,
  parameter int CLKS_PER_BYTE = 4,
  parameter int SETUP_DELAY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  reg_rdata,
  output logic [15:0] src_addr,
  output logic        src_vram,
  output logic        src_rd,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic        dma_active,
  output logic        cpu_bus_ok,
  output logic        intq_mask,
  output logic        done
);

  localparam int XFER_LEN  = NUM_BYTES * CLKS_PER_BYTE;
  localparam int XCW       = $clog2(XFER_LEN);
  localparam int SHIFT     = $clog2(CLKS_PER_BYTE);
  localparam int SCW       = $clog2(SETUP_DELAY + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_base;
  logic [7:0]      r_src_base;
  logic            r_setup_pending;
  logic [SCW-1:0]  r_setup_cnt;
  logic [XCW-1:0]  r_xfer_cnt, w_xfer_cnt_next;

  logic            w_start;
  logic            w_expire;
  logic            w_xfer_last;
  logic [7:0]      w_idx;
  logic [15:0]     w_src;
  logic            w_unused;

  // cpu_rd has no effect on state: FF46 reads are served straight from r_base.
  assign w_unused = cpu_rd;

  assign w_start     = cpu_wr && (cpu_addr == 16'hFF46);
  // A write landing on the expiry edge restarts the delay instead of expiring it.
  assign w_expire    = r_setup_pending && (r_setup_cnt == SCW'(SETUP_DELAY)) && !w_start;
  assign w_xfer_last = (r_state == XFER) && (r_xfer_cnt == XCW'(XFER_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_xfer_cnt      <= '0;
      r_base          <= 8'h00;
      r_src_base      <= 8'h00;
      r_setup_pending <= 1'b0;
      r_setup_cnt     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_xfer_cnt <= w_xfer_cnt_next;
      if (w_start) begin
        r_base          <= cpu_wdata;
        r_setup_pending <= 1'b1;
        r_setup_cnt     <= SCW'(1);
      end else if (r_setup_pending) begin
        if (w_expire) begin
          r_setup_pending <= 1'b0;
          r_setup_cnt     <= '0;
        end else begin
          r_setup_cnt <= r_setup_cnt + SCW'(1);
        end
      end
      if (w_expire) r_src_base <= r_base;
    end
  end

  // Setup expiry wins over the natural end of a running transfer.
  always_comb begin
    w_state_next    = r_state;
    w_xfer_cnt_next = r_xfer_cnt;
    if (w_expire) begin
      w_state_next    = XFER;
      w_xfer_cnt_next = '0;
    end else begin
      case (r_state)
        IDLE: w_xfer_cnt_next = '0;
        XFER: begin
          if (w_xfer_last) begin
            w_state_next    = IDLE;
            w_xfer_cnt_next = '0;
          end else begin
            w_xfer_cnt_next = r_xfer_cnt + XCW'(1);
          end
        end
        default: begin
          w_state_next    = IDLE;
          w_xfer_cnt_next = '0;
        end
      endcase
    end
  end

  assign w_idx = 8'(r_xfer_cnt >> SHIFT);

  always_comb begin
    w_src = {r_src_base, 8'h00} + {8'h00, w_idx};
    // Echo RAM (E000-FDFF) mirrors C000-DDFF.
    if (r_src_base >= 8'hE0) w_src[13] = 1'b0;
  end

  always_comb begin
    reg_rdata  = r_base;
    src_addr   = 16'h0000;
    src_vram   = 1'b0;
    src_rd     = 1'b0;
    oam_addr   = 8'h00;
    oam_we     = 1'b0;
    dma_active = 1'b0;
    intq_mask  = 1'b0;
    done       = 1'b0;
    cpu_bus_ok = 1'b1;
    if (r_state == XFER) begin
      src_addr   = w_src;
      src_vram   = (w_src[15:13] == 3'b100);
      src_rd     = 1'b1;
      oam_addr   = w_idx;
      oam_we     = 1'b1;
      dma_active = 1'b1;
      intq_mask  = 1'b1;
      done       = w_xfer_last;
      cpu_bus_ok = ((cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE)) ||
                   (cpu_addr == 16'hFF46);
    end
  end

endmodule
